// File: rtl/trace_drain_controller.sv
// trace_drain_controller
//   Takes completed trace records from the writeback tracker, stamps each one
//   with a free-running cycle count, queues it in a small FIFO and streams it
//   out as one header beat (timestamp) followed by RECORD_WIDTH/OUT_WIDTH body
//   beats, least-significant word first. When the FIFO is full, new records are
//   dropped and counted so a stalled consumer never stalls the core.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   enable_i             gates record capture only; draining continues when low
//   flush_i              one-cycle pulse, discards all queued records
//   trace_data_ready     record strobe, one cycle per record
//   trace_record_i       packed trace record
//   out_valid_o/out_data_o/out_last_o/out_ready_i   output beat stream
//   fifo_level_o         queued records, not counting the one being serialized
//   drop_count_o         saturating count of records lost to a full FIFO
//   busy_o               serializer active or records queued
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | serializer empty, waiting for a queued record
// HEADER | presenting the stored timestamp beat
// BODY   | presenting record words, index 0 .. RECORD_WIDTH/OUT_WIDTH-1

module trace_drain_controller #(
  parameter int RECORD_WIDTH = 128,
  parameter int OUT_WIDTH    = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int DROP_WIDTH   = 16,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic                    flush_i,
  input  logic                    trace_data_ready,
  input  logic [RECORD_WIDTH-1:0] trace_record_i,
  output logic                    out_valid_o,
  output logic [OUT_WIDTH-1:0]    out_data_o,
  output logic                    out_last_o,
  input  logic                    out_ready_i,
  output logic [LVL_W-1:0]        fifo_level_o,
  output logic [DROP_WIDTH-1:0]   drop_count_o,
  output logic                    busy_o
);

  localparam int BEATS   = RECORD_WIDTH / OUT_WIDTH;
  localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENTRY_W = OUT_WIDTH + RECORD_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [OUT_WIDTH-1:0]    ts_q;
  logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]        level_q;
  logic [DROP_WIDTH-1:0]   drop_q;
  logic [OUT_WIDTH-1:0]    hdr_q, hdr_d;
  logic [RECORD_WIDTH-1:0] rec_q, rec_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic strobe_en;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic drop;
  logic pop;

  // Full is judged on the registered level, so a same-cycle pop never
  // makes room for an incoming record.
  assign strobe_en  = trace_data_ready & enable_i & ~flush_i;
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push       = strobe_en & ~fifo_full;
  assign drop       = strobe_en & fifo_full;

  // ------------------------------------------------------------------
  // Timestamp
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + OUT_WIDTH'(1);
  end

  // ------------------------------------------------------------------
  // Record FIFO: entry = {timestamp, record}
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ts_q, trace_record_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       drop_q <= '0;
    else if (drop && (drop_q != '1)) drop_q <= drop_q + DROP_WIDTH'(1);
  end

  // ------------------------------------------------------------------
  // Serializer FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      rec_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      rec_q   <= rec_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    rec_d       = rec_q;
    idx_d       = idx_q;
    pop         = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A flush in the same cycle wins over loading a queued record.
        if (!fifo_empty && !flush_i) begin
          pop            = 1'b1;
          {hdr_d, rec_d} = mem_q[rd_ptr_q];
          state_d        = ST_HEADER;
        end
      end

      ST_HEADER: begin
        out_valid_o = 1'b1;
        out_data_o  = hdr_q;
        if (out_ready_i) begin
          idx_d   = '0;
          state_d = ST_BODY;
        end
      end

      ST_BODY: begin
        out_valid_o = 1'b1;
        out_data_o  = rec_q[OUT_WIDTH-1:0];
        out_last_o  = (idx_q == LAST_IDX);
        if (out_ready_i) begin
          if (idx_q == LAST_IDX) begin
            // Chain straight into the next header to avoid a bubble.
            if (!fifo_empty && !flush_i) begin
              pop            = 1'b1;
              {hdr_d, rec_d} = mem_q[rd_ptr_q];
              state_d        = ST_HEADER;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            rec_d = rec_q >> OUT_WIDTH;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_level_o = level_q;
  assign drop_count_o = drop_q;
  assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_trace_drain_controller.sv
// tb_trace_drain_controller
//   Scoreboard bench for trace_drain_controller. Each strobe that should reach
//   the output pushes its header and body beats onto an expected queue; a
//   monitor pops and compares on every accepted beat. Directed sequences cover
//   latency, back-pressure, overflow, back-to-back drain, flush, enable and
//   asynchronous reset.

module tb_trace_drain_controller;

  localparam int RW = 128;
  localparam int OW = 32;
  localparam int FD = 8;
  localparam int DW = 16;
  localparam int LW = $clog2(FD) + 1;
  localparam int NB = RW / OW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          trace_data_ready = 1'b0;
  logic [RW-1:0] trace_record_i = '0;
  logic          out_ready_i = 1'b1;
  logic          out_valid_o;
  logic [OW-1:0] out_data_o;
  logic          out_last_o;
  logic [LW-1:0] fifo_level_o;
  logic [DW-1:0] drop_count_o;
  logic          busy_o;

  trace_drain_controller #(
    .RECORD_WIDTH(RW), .OUT_WIDTH(OW), .FIFO_DEPTH(FD), .DROP_WIDTH(DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable_i        (enable_i),
    .flush_i         (flush_i),
    .trace_data_ready(trace_data_ready),
    .trace_record_i  (trace_record_i),
    .out_valid_o     (out_valid_o),
    .out_data_o      (out_data_o),
    .out_last_o      (out_last_o),
    .out_ready_i     (out_ready_i),
    .fifo_level_o    (fifo_level_o),
    .drop_count_o    (drop_count_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [OW:0] exp_q [$];
  logic [OW-1:0] tb_ts;

  localparam logic [RW-1:0] REC1 = 128'h44443333_22221111_00000000_DEADBEEF;
  localparam logic [RW-1:0] REC2 = 128'h0BADF00D_13579BDF_2468ACE0_CAFEF00D;

  // Reference cycle count; mirrors the externally visible timestamp rule.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_ts <= '0;
    else      tb_ts <= tb_ts + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexp_beat_queue", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [OW:0] e;
        e = exp_q.pop_front();
        chk("beat_data", 64'(out_data_o), 64'(e[OW-1:0]));
        chk("beat_last", 64'(out_last_o), 64'(e[OW]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [RW-1:0] rec, input bit keep);
    trace_data_ready = 1'b1;
    trace_record_i   = rec;
    if (keep) begin
      exp_q.push_back({1'b0, tb_ts});
      for (int i = 0; i < NB; i++)
        exp_q.push_back({(i == NB - 1), rec[i*OW +: OW]});
    end
    cyc();
    trace_data_ready = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy_o) && k < max_cyc) begin
      cyc();
      k++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    logic [RW-1:0] rec;

    // Reset values
    #12;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_data",  64'(out_data_o),  64'd0);
    chk("rst_last",  64'(out_last_o),  64'd0);
    chk("rst_level", 64'(fifo_level_o), 64'd0);
    chk("rst_drop",  64'(drop_count_o), 64'd0);
    chk("rst_busy",  64'(busy_o),       64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single record at ts = 10, latency and last flag
    while (tb_ts != 10) cyc();
    strobe(REC1, 1'b1);
    @(negedge clk);
    chk("lat_n1_valid", 64'(out_valid_o), 64'd0);
    for (int i = 2; i <= 7; i++) begin
      cyc();
      @(negedge clk);
      chk("t1_valid", 64'(out_valid_o), 64'(i <= 6));
      chk("t1_last",  64'(out_last_o),  64'(i == 6));
    end
    wait_drain(20);

    // Back-pressure on beat 2
    strobe(REC1, 1'b1);
    cyc();
    cyc();
    cyc();
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_data",  64'(out_data_o),  64'd0);
      chk("bp_hold_valid", 64'(out_valid_o), 64'd1);
      cyc();
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_hold_data4", 64'(out_data_o), 64'd0);
    wait_drain(20);

    // Overflow: 11 strobes against a stalled consumer
    out_ready_i = 1'b0;
    for (int i = 0; i < 11; i++) begin
      for (int w = 0; w < NB; w++) rec[w*OW +: OW] = OW'(32'h5100_0000 + i * 16 + w);
      strobe(rec, i < 9);
    end
    chk("ovf_level", 64'(fifo_level_o), 64'd8);
    chk("ovf_drop",  64'(drop_count_o), 64'd2);
    chk("ovf_valid", 64'(out_valid_o),  64'd1);
    out_ready_i = 1'b1;
    wait_drain(100);

    // Back-to-back drain of 3 records
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < NB; w++) rec[w*OW +: OW] = OW'(32'h7700_0000 + i * 16 + w);
      strobe(rec, 1'b1);
    end
    out_ready_i = 1'b1;
    run = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid_o) run++;
      else if (run > 0) break;
      cyc();
    end
    chk("b2b_run", 64'(run), 64'd15);
    wait_drain(20);

    // Flush during body of A with B and C queued
    out_ready_i = 1'b0;
    strobe(REC2, 1'b1);
    strobe(REC1, 1'b0);
    strobe(~REC2, 1'b0);
    out_ready_i = 1'b1;
    cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_level", 64'(fifo_level_o), 64'd0);
    wait_drain(30);
    repeat (10) cyc();
    chk("flush_tail_left", 64'(exp_q.size()), 64'd0);

    // Disabled capture
    enable_i = 1'b0;
    strobe(REC1, 1'b0);
    strobe(REC2, 1'b0);
    strobe(REC1, 1'b0);
    repeat (10) cyc();
    chk("en_drop",  64'(drop_count_o), 64'd2);
    chk("en_level", 64'(fifo_level_o), 64'd0);
    chk("en_busy",  64'(busy_o),       64'd0);
    enable_i = 1'b1;

    // Async reset mid-body
    strobe(REC1, 1'b1);
    cyc();
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid_o),  64'd0);
    chk("arst_data",  64'(out_data_o),   64'd0);
    chk("arst_last",  64'(out_last_o),   64'd0);
    chk("arst_busy",  64'(busy_o),       64'd0);
    chk("arst_drop",  64'(drop_count_o), 64'd0);
    chk("arst_level", 64'(fifo_level_o), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    while (tb_ts != 5) cyc();
    strobe(REC2, 1'b1);
    wait_drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
